// File: rtl/cpu_pkg.sv
// Shared widths, fetch FSM state encoding and FIFO entry layout
// for the instruction fetch stage.
package cpu_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] word_align(
        input logic [ADDR_W-1:0] a
    );
        return a & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch stage bus: instruction memory req/ack, branch redirect,
// and the valid/ready hand-off towards decode.
interface fetch_unit_if;
    import cpu_pkg::*;

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               redirect;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               inst_valid;
    logic [INSTR_W-1:0] inst_data;
    logic [ADDR_W-1:0]  inst_pc;
    logic [ADDR_W-1:0]  inst_pc4;
    logic               inst_ready;

    modport master (
        output imem_req, imem_addr,
        output inst_valid, inst_data, inst_pc, inst_pc4,
        input  imem_ack, imem_rdata,
        input  redirect, redirect_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        input  inst_valid, inst_data, inst_pc, inst_pc4,
        output imem_ack, imem_rdata,
        output redirect, redirect_pc,
        output inst_ready
    );

endinterface

// File: rtl/fetch_unit_fifo.sv
// Prefetch FIFO holding {pc, instr}; flush beats push and pop.
// Head reads as zero while empty so decode never sees stale words.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic                   pop,
    input  logic                   flush,
    input  fetch_entry_t           wdata,
    output fetch_entry_t           rdata,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

    fetch_entry_t   mem_q [DEPTH];
    logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PW:0]    count_q, count_d;
    logic           do_push;
    logic           do_pop;

    always_comb begin
        do_push  = push && !flush;
        do_pop   = pop && !flush && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_push) mem_q[wr_ptr_q] <= wdata;
    end

    // The fetch FSM only issues with room left, so a full push is a bug.
    always_ff @(posedge clk) begin
        if (!reset) assert (!(do_push && count_q == FULL_CNT));
    end

    assign empty = (count_q == '0);
    assign count = count_q;
    assign rdata = empty ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_unit.sv
// Decoupled fetch stage: owns the fetch PC, keeps one imem request
// in flight, buffers words for decode and handles branch redirects.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    fetch_unit_if.master bus
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(DEPTH - 1);

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] pend_pc_q, pend_pc_d;
    logic [ADDR_W-1:0] rpc;
    logic              req;
    logic              push;
    logic              pop;
    logic              flush;
    logic              empty;
    logic [CW-1:0]     count;
    fetch_entry_t      head;
    fetch_entry_t      wentry;

    always_comb begin
        rpc        = word_align(bus.redirect_pc);
        pop        = !empty && bus.inst_ready;
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pend_pc_d  = pend_pc_q;
        req        = 1'b0;
        push       = 1'b0;
        flush      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = rpc;
                    state_d    = REQ;
                end else if (count < FULL_CNT) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                req = 1'b1;
                if (bus.imem_ack && bus.redirect) begin
                    flush      = 1'b1;
                    fetch_pc_d = rpc;
                end else if (bus.imem_ack) begin
                    push       = 1'b1;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    // Stop issuing once this push fills the last slot.
                    if (!(pop || count < LAST_CNT)) state_d = IDLE;
                end else if (bus.redirect) begin
                    flush     = 1'b1;
                    pend_pc_d = rpc;
                    state_d   = DROP;
                end
            end
            DROP: begin
                req = 1'b1;
                if (bus.redirect) flush = 1'b1;
                if (bus.imem_ack) begin
                    fetch_pc_d = bus.redirect ? rpc : pend_pc_q;
                    state_d    = REQ;
                end else if (bus.redirect) begin
                    pend_pc_d = rpc;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            pend_pc_q  <= RESET_PC;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pend_pc_q  <= pend_pc_d;
        end
    end

    assign wentry.pc    = fetch_pc_q;
    assign wentry.instr = bus.imem_rdata;

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .wdata (wentry),
        .rdata (head),
        .empty (empty),
        .count (count)
    );

    assign bus.imem_req   = req;
    assign bus.imem_addr  = fetch_pc_q;
    assign bus.inst_valid = !empty;
    assign bus.inst_data  = head.instr;
    assign bus.inst_pc    = head.pc;
    assign bus.inst_pc4   = head.pc + 32'd4;

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: stream-level reference model plus directed
// redirect/backpressure/wrap scenarios and a randomized soak.
module tb_fetch_unit;

    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    fetch_unit_if bus ();
    fetch_unit_if bus2 ();

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (rst),
        .bus   (bus)
    );

    fetch_unit #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) dut_wrap (
        .clk   (clk),
        .reset (rst),
        .bus   (bus2)
    );

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign bus2.imem_ack    = bus2.imem_req;
    assign bus2.imem_rdata  = word_of(bus2.imem_addr);
    assign bus2.redirect    = 1'b0;
    assign bus2.redirect_pc = 32'h0;
    assign bus2.inst_ready  = 1'b1;

    int checks = 0;
    int errors = 0;

    // stimulus controls
    bit          rst_c, rdy_c, redir_c, rand_mode, fired;
    logic [31:0] rpc_c, trig_addr, trig_pc;
    int          lat_c, trig_mode, wait_cnt, lat_cur, ack_cnt;

    // reference model: expected stream of buffered pcs
    logic [31:0] q[$];
    logic [31:0] delivered[$];
    logic [31:0] ack_log[$];
    logic [31:0] wrap_pc[$];
    logic [31:0] wrap_pc4[$];
    logic [31:0] nxt, prev_addr;
    bit          drop, exp_req, pred_ok, prev_req, prev_ack;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    task automatic chk1(input string n, input logic act, input logic exp);
        chk(n, {31'b0, act}, {31'b0, exp});
    endtask

    task automatic chk_at(input string n, input logic [31:0] qq[$],
                          input int i, input logic [31:0] exp);
        if (i < qq.size()) chk(n, qq[i], exp);
        else chk({n, "_missing"}, 32'(qq.size()), 32'(i + 1));
    endtask

    task automatic tick();
        logic        req, ack, valid, redir, rdy;
        logic [31:0] addr, rpc;
        int          size_pre;
        @(negedge clk);
        req   = bus.imem_req;
        addr  = bus.imem_addr;
        valid = bus.inst_valid;
        if (pred_ok) begin
            chk1("imem_req", req, exp_req);
            chk1("inst_valid", valid, q.size() != 0);
            if (q.size() != 0) begin
                chk("inst_pc", bus.inst_pc, q[0]);
                chk("inst_data", bus.inst_data, word_of(q[0]));
                chk("inst_pc4", bus.inst_pc4, q[0] + 32'd4);
            end
            if (req) chk("addr_align", {30'b0, addr[1:0]}, 32'h0);
            if (req && !drop) chk("imem_addr", addr, nxt);
            if (req && prev_req && !prev_ack)
                chk("addr_hold", addr, prev_addr);
        end
        if (bus2.inst_valid && wrap_pc.size() < 3) begin
            wrap_pc.push_back(bus2.inst_pc);
            wrap_pc4.push_back(bus2.inst_pc4);
            chk("wrap_data", bus2.inst_data, word_of(bus2.inst_pc));
        end

        redir = redir_c;
        rpc   = rpc_c;
        rdy   = rdy_c;
        if (trig_mode == 1 && req && addr == trig_addr && wait_cnt == 0) begin
            redir = 1'b1;
            rpc = trig_pc;
            trig_mode = 0;
            fired = 1'b1;
            ack_log.delete();
        end
        ack = 1'b0;
        if (req && !rst_c) begin
            if (wait_cnt == 0)
                lat_cur = rand_mode ? int'($urandom_range(0, 3)) : lat_c;
            if (wait_cnt >= lat_cur) begin
                ack = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
        if (trig_mode == 2 && q.size() == 3 && ack) begin
            redir = 1'b1;
            rpc = trig_pc;
            rdy = 1'b1;
            trig_mode = 0;
            fired = 1'b1;
        end

        rst             = rst_c;
        bus.imem_ack    = ack;
        bus.imem_rdata  = ack ? word_of(addr) : $urandom;
        bus.redirect    = redir;
        bus.redirect_pc = rpc;
        bus.inst_ready  = rdy;
        redir_c = 1'b0;
        if (req && ack) begin
            ack_cnt++;
            ack_log.push_back(addr);
        end

        prev_req  = req;
        prev_addr = addr;
        prev_ack  = ack;
        if (rst_c) begin
            q.delete();
            delivered.delete();
            wrap_pc.delete();
            wrap_pc4.delete();
            nxt = 32'h0;
            drop = 1'b0;
            exp_req = 1'b0;
            pred_ok = 1'b1;
            return;
        end
        size_pre = q.size();
        if (valid && rdy && q.size() != 0) delivered.push_back(q.pop_front());
        if (redir) begin
            q.delete();
            delivered.delete();
            nxt = rpc & ~32'h3;
            drop = req && !ack;
            exp_req = 1'b1;
        end else if (!req) begin
            exp_req = size_pre < DEPTH;
        end else if (!ack) begin
            exp_req = 1'b1;
        end else if (drop) begin
            drop = 1'b0;
            exp_req = 1'b1;
        end else begin
            chk1("fifo_room", q.size() < DEPTH, 1'b1);
            q.push_back(nxt);
            nxt = nxt + 32'd4;
            exp_req = q.size() < DEPTH;
        end
    endtask

    task automatic do_reset();
        rst_c = 1'b1;
        tick();
        tick();
        rst_c = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        bus.imem_ack = 1'b0;
        bus.imem_rdata = 32'h0;
        bus.redirect = 1'b0;
        bus.redirect_pc = 32'h0;
        bus.inst_ready = 1'b0;
        rst_c = 1'b1; rdy_c = 1'b1; redir_c = 1'b0; rpc_c = 32'h0;
        rand_mode = 1'b0; lat_c = 0; trig_mode = 0; fired = 1'b0;
        wait_cnt = 0; lat_cur = 0; ack_cnt = 0;
        pred_ok = 1'b0; drop = 1'b0; exp_req = 1'b0; nxt = 32'h0;
        prev_req = 1'b0; prev_ack = 1'b0; prev_addr = 32'h0;

        // zero-wait stream, latency and reset values
        do_reset();
        tick();
        chk1("rst_req", bus.imem_req, 1'b0);
        chk1("rst_valid", bus.inst_valid, 1'b0);
        chk("rst_data", bus.inst_data, 32'h0);
        chk("rst_pc", bus.inst_pc, 32'h0);
        chk("rst_pc4", bus.inst_pc4, 32'd4);
        tick();
        chk1("c1_req", bus.imem_req, 1'b1);
        chk("c1_addr", bus.imem_addr, 32'h0);
        chk1("c1_valid", bus.inst_valid, 1'b0);
        tick();
        chk1("c2_valid", bus.inst_valid, 1'b1);
        chk("c2_pc", bus.inst_pc, 32'h0);
        chk("c2_data", bus.inst_data, 32'h1357_6420);
        chk("c2_pc4", bus.inst_pc4, 32'd4);
        tick();
        chk("c3_pc", bus.inst_pc, 32'd4);
        chk("c3_pc4", bus.inst_pc4, 32'd8);
        repeat (10) tick();
        chk_at("wrap_pc0", wrap_pc, 0, 32'hFFFF_FFF8);
        chk_at("wrap_pc1", wrap_pc, 1, 32'hFFFF_FFFC);
        chk_at("wrap_pc2", wrap_pc, 2, 32'h0000_0000);
        chk_at("wrap_pc4_1", wrap_pc4, 1, 32'h0000_0000);
        chk_at("wrap_pc4_2", wrap_pc4, 2, 32'h0000_0004);

        // backpressure: exactly DEPTH words accepted, then in-order drain
        rdy_c = 1'b0;
        do_reset();
        ack_cnt = 0;
        repeat (12) tick();
        chk("bp_acks", 32'(ack_cnt), 32'd4);
        chk1("bp_req", bus.imem_req, 1'b0);
        chk("bp_head", bus.inst_pc, 32'h0);
        rdy_c = 1'b1;
        repeat (8) tick();
        for (int i = 0; i < 5; i++)
            chk_at("bp_order", delivered, i, 32'(i * 4));

        // slow memory, redirect during the first cycle of fetch at 8
        lat_c = 3;
        do_reset();
        trig_mode = 1; trig_addr = 32'h8; trig_pc = 32'h40; fired = 1'b0;
        for (int i = 0; i < 60 && !fired; i++) tick();
        chk1("t3_fired", fired, 1'b1);
        repeat (20) tick();
        chk_at("t3_dropped", ack_log, 0, 32'h8);
        chk_at("t3_next", ack_log, 1, 32'h40);
        chk_at("t3_first", delivered, 0, 32'h40);

        // redirect together with ack and pop, 3 entries buffered
        lat_c = 0; rdy_c = 1'b0;
        do_reset();
        trig_mode = 2; trig_pc = 32'h80; fired = 1'b0;
        for (int i = 0; i < 30 && !fired; i++) tick();
        chk1("t4_fired", fired, 1'b1);
        tick();
        chk1("t4_valid", bus.inst_valid, 1'b0);
        chk1("t4_req", bus.imem_req, 1'b1);
        chk("t4_addr", bus.imem_addr, 32'h80);
        rdy_c = 1'b1;
        repeat (6) tick();
        chk_at("t4_first", delivered, 0, 32'h80);

        // two redirects while dropping
        lat_c = 3;
        do_reset();
        trig_mode = 1; trig_addr = 32'h4; trig_pc = 32'h100; fired = 1'b0;
        for (int i = 0; i < 60 && !fired; i++) tick();
        chk1("t5_fired", fired, 1'b1);
        redir_c = 1'b1; rpc_c = 32'h200;
        tick();
        repeat (25) tick();
        chk_at("t5_dropped", ack_log, 0, 32'h4);
        chk_at("t5_next", ack_log, 1, 32'h200);
        chk_at("t5_first", delivered, 0, 32'h200);

        // unaligned redirect target
        lat_c = 0;
        do_reset();
        repeat (3) tick();
        redir_c = 1'b1; rpc_c = 32'h23;
        tick();
        repeat (5) tick();
        chk_at("t6_align", delivered, 0, 32'h20);

        // reset while a fetch is pending
        lat_c = 3;
        do_reset();
        repeat (3) tick();
        chk1("t7_pending", bus.imem_req, 1'b1);
        rst_c = 1'b1;
        tick();
        rst_c = 1'b0;
        tick();
        chk1("t7_req", bus.imem_req, 1'b0);
        chk1("t7_valid", bus.inst_valid, 1'b0);

        // randomized soak
        rand_mode = 1'b1;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            rdy_c = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 15) == 0) begin
                redir_c = 1'b1;
                rpc_c = $urandom;
            end
            rst_c = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst_c = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
